// File: rtl/pc_fetch_sequencer_if.sv
// Handshake bundle between the PC fetch sequencer and its hazard/branch and I-cache neighbours.
// The master side is the sequencer itself; the slave side is the surrounding pipeline.
interface pc_fetch_sequencer_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall_i;
  logic             icache_ready_i;
  logic             redirect_valid_i;
  logic [XLEN-1:0]  redirect_tgt_i;
  logic             trap_valid_i;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_plus_inc_o;
  logic             fetch_req_o;
  logic             fetch_valid_o;
  logic             misalign_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    input  stall_i, icache_ready_i, redirect_valid_i, redirect_tgt_i, trap_valid_i,
    output pc_o, pc_plus_inc_o, fetch_req_o, fetch_valid_o, misalign_o, stall_cnt_o
  );

  modport slave (
    output stall_i, icache_ready_i, redirect_valid_i, redirect_tgt_i, trap_valid_i,
    input  pc_o, pc_plus_inc_o, fetch_req_o, fetch_valid_o, misalign_o, stall_cnt_o
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Registered program-counter sequencer: holds on stall/miss, applies redirects and traps,
// queues a redirect or trap that arrives mid-miss, and counts non-advancing fetch cycles.
module pc_fetch_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              INC          = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pc_fetch_sequencer_if.master bus
);

  localparam int ALIGN_W = $clog2(INC);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             req_en_q;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_trap_q, pend_trap_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
  logic             misalign_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  redir_aligned;
  logic             redir_low_set;
  logic             fetch_valid;
  logic             applied;
  logic             redir_used;

  assign pc_inc        = pc_q + XLEN'(INC);
  assign redir_aligned = {bus.redirect_tgt_i[XLEN-1:ALIGN_W], {ALIGN_W{1'b0}}};
  assign redir_low_set = |bus.redirect_tgt_i[ALIGN_W-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_trap_d = pend_trap_q;
    pend_tgt_d  = pend_tgt_q;
    fetch_valid = 1'b0;
    applied     = 1'b0;
    redir_used  = 1'b0;

    if (req_en_q) begin
      case (state_q)
        S_RUN: begin
          if (bus.trap_valid_i) begin
            pc_d    = TRAP_VECTOR;
            applied = 1'b1;
          end else if (bus.redirect_valid_i) begin
            pc_d       = redir_aligned;
            applied    = 1'b1;
            redir_used = 1'b1;
          end else if (bus.icache_ready_i && !bus.stall_i) begin
            pc_d        = pc_inc;
            fetch_valid = 1'b1;
          end else if (!bus.icache_ready_i) begin
            state_d = S_MISS;
          end
        end

        S_MISS: begin
          if (bus.icache_ready_i) begin
            // Miss completes: a same-cycle event beats anything queued earlier.
            state_d     = S_RUN;
            pend_vld_d  = 1'b0;
            pend_trap_d = 1'b0;
            if (bus.trap_valid_i) begin
              pc_d    = TRAP_VECTOR;
              applied = 1'b1;
            end else if (bus.redirect_valid_i) begin
              pc_d       = redir_aligned;
              applied    = 1'b1;
              redir_used = 1'b1;
            end else if (pend_vld_q) begin
              pc_d    = pend_tgt_q;
              applied = 1'b1;
            end else if (!bus.stall_i) begin
              pc_d        = pc_inc;
              fetch_valid = 1'b1;
            end
          end else if (bus.trap_valid_i) begin
            pend_vld_d  = 1'b1;
            pend_trap_d = 1'b1;
            pend_tgt_d  = TRAP_VECTOR;
          end else if (bus.redirect_valid_i && !pend_trap_q) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = redir_aligned;
            redir_used = 1'b1;
          end
        end

        default: state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      req_en_q    <= 1'b0;
      pc_q        <= RESET_VECTOR;
      pend_vld_q  <= 1'b0;
      pend_trap_q <= 1'b0;
      pend_tgt_q  <= '0;
      misalign_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      req_en_q    <= 1'b1;
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_trap_q <= pend_trap_d;
      pend_tgt_q  <= pend_tgt_d;
      misalign_q  <= redir_used && redir_low_set;
      if (req_en_q && !fetch_valid && !applied && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.pc_plus_inc_o = pc_inc;
  assign bus.fetch_req_o   = req_en_q;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.misalign_o    = misalign_q;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule
